// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Fixed-select or round-robin arbitration; the rotation pointer is shared by both modes.
module stream_mux_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_ch_r;
  logic                out_valid_r;
  logic [SEL_W-1:0]    last_grant_r;

  logic                load_en_s;
  logic                sel_ok_s;
  logic                rr_found_s;
  logic [SEL_W-1:0]    rr_idx_s;
  logic [SEL_W-1:0]    probe_s;
  logic                hit_s;
  logic                cand_valid_s;
  logic [SEL_W-1:0]    cand_idx_s;
  logic                grant_s;
  logic [WIDTH-1:0]    sel_data_s;
  logic [CHANNELS-1:0] in_ready_s;

  assign load_en_s = !out_valid_r || out_ready;
  assign sel_ok_s  = (int'(sel) < CHANNELS);

  // Round-robin search: first valid channel after last_grant, wrapping back to last_grant.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    probe_s    = '0;
    hit_s      = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      probe_s    = SEL_W'((int'(last_grant_r) + k) % CHANNELS);
      hit_s      = !rr_found_s && in_valid[probe_s];
      rr_idx_s   = hit_s ? probe_s : rr_idx_s;
      rr_found_s = rr_found_s | hit_s;
    end
  end

  // Candidate selection by mode, and the grant qualified by output availability.
  always_comb begin
    cand_valid_s = 1'b0;
    cand_idx_s   = '0;
    if (mode) begin
      cand_valid_s = rr_found_s;
      cand_idx_s   = rr_idx_s;
    end else if (sel_ok_s) begin
      cand_valid_s = in_valid[sel];
      cand_idx_s   = sel;
    end else begin
      cand_valid_s = 1'b0;
      cand_idx_s   = '0;
    end
    grant_s = cand_valid_s && load_en_s && rst_n;
  end

  // One-hot ready and data select for the granted channel.
  always_comb begin
    in_ready_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready_s[i] = grant_s && (cand_idx_s == SEL_W'(i));
      sel_data_s    = (cand_idx_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // Output register and rotation pointer; reset drops any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r   <= '0;
      out_ch_r     <= '0;
      out_valid_r  <= 1'b0;
      last_grant_r <= SEL_W'(CHANNELS - 1);
    end else if (grant_s) begin
      out_data_r   <= sel_data_s;
      out_ch_r     <= cand_idx_s;
      out_valid_r  <= 1'b1;
      last_grant_r <= cand_idx_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (WIDTH=4, CHANNELS=4) with hand-computed expectations.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int total_cnt = 0;
  int bad_cnt   = 0;

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_data   = 16'h8421;
    in_valid  = 4'hf;
    out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_ch",    32'(out_ch),    32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    step();
    rst_n = 1'b1;

    // Fixed mode, sel stepping 0..3
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check("fix_ready", 32'(in_ready), 32'(4'b0001 << i));
      step();
      check("fix_data",  32'(out_data),  32'(4'b0001 << i));
      check("fix_ch",    32'(out_ch),    32'(i));
      check("fix_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin, all valid: last grant was 3, so rotation restarts at 0
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      step();
      check("rr_ch",    32'(out_ch),    32'(k % 4));
      check("rr_data",  32'(out_data),  32'(4'b0001 << (k % 4)));
      check("rr_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin, only channels 1 and 3 valid
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr13_ready", 32'(in_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      step();
      check("rr13_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure: load ch0, then stall three cycles
    in_valid = 4'hf;
    step();
    check("bp_load_ch", 32'(out_ch), 32'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_ch",    32'(out_ch),    32'd0);
      check("bp_data",  32'(out_data),  32'd1);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(in_ready), 32'h2);
    step();
    check("bp_resume_ch1", 32'(out_ch), 32'd1);
    step();
    check("bp_resume_ch2", 32'(out_ch),    32'd2);
    check("bp_resume_vld", 32'(out_valid), 32'd1);

    // Reset mid-stream, between edges
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data",  32'(out_data),  32'd0);
    check("mrst_ready", 32'(in_ready),  32'd0);
    step();
    check("mrst_hold", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mrst_rel_ready", 32'(in_ready), 32'h1);
    step();
    check("mrst_first_ch",  32'(out_ch),    32'd0);
    check("mrst_first_vld", 32'(out_valid), 32'd1);

    // Fixed sel=2 with channel 2 idle: pending word drains, then nothing
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    check("idle_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_valid", 32'(out_valid), 32'd0);
    end
    check("idle_ch_hold", 32'(out_ch), 32'd0);
    in_valid = 4'hf;
    #1;
    check("idle_wake_ready", 32'(in_ready), 32'h4);
    step();
    check("idle_wake_valid", 32'(out_valid), 32'd1);
    check("idle_wake_ch",    32'(out_ch),    32'd2);
    check("idle_wake_data",  32'(out_data),  32'd4);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
